// File: rtl/aibcr3_bsr_chain_nch_if.sv
// Boundary-scan chain signal bundle: JTAG control/scan plus per-channel TX/RX buses.
// The master side drives the chain inputs; the slave side is the chain itself.
interface aibcr3_bsr_chain_nch_if #(
    parameter int unsigned NCH = 8
);
    logic           jtag_tx_scan_in;
    logic           jtag_tx_scanen_in;
    logic           jtag_capture;
    logic           jtag_update;
    logic           jtag_mode_in;
    logic           jtag_intest;
    logic [NCH-1:0] shift_en;
    logic [NCH-1:0] idata0_in0;
    logic [NCH-1:0] idata0_in1;
    logic [NCH-1:0] idata1_in0;
    logic [NCH-1:0] idata1_in1;
    logic [NCH-1:0] itxen_in0;
    logic [NCH-1:0] itxen_in1;
    logic [NCH-1:0] odat0_aib;
    logic [NCH-1:0] odat1_aib;
    logic [NCH-1:0] idata0_out;
    logic [NCH-1:0] idata1_out;
    logic [NCH-1:0] itxen_out;
    logic [NCH-1:0] odat0_out;
    logic [NCH-1:0] odat1_out;
    logic           jtag_rx_scan_out;
    logic           scan_full;

    modport master (
        output jtag_tx_scan_in, jtag_tx_scanen_in, jtag_capture, jtag_update,
               jtag_mode_in, jtag_intest, shift_en, idata0_in0, idata0_in1,
               idata1_in0, idata1_in1, itxen_in0, itxen_in1, odat0_aib, odat1_aib,
        input  idata0_out, idata1_out, itxen_out, odat0_out, odat1_out,
               jtag_rx_scan_out, scan_full
    );

    modport slave (
        input  jtag_tx_scan_in, jtag_tx_scanen_in, jtag_capture, jtag_update,
               jtag_mode_in, jtag_intest, shift_en, idata0_in0, idata0_in1,
               idata1_in0, idata1_in1, itxen_in0, itxen_in1, odat0_aib, odat1_aib,
        output idata0_out, idata1_out, itxen_out, odat0_out, odat1_out,
               jtag_rx_scan_out, scan_full
    );
endinterface

// File: rtl/aibcr3_bsr_chain_nch.sv
// AIB boundary-scan chain, 3 cells per channel (data0, data1, txen) with capture/update.
// Define AIBCR3_BSR_REDUNDANCY_EN to enable neighbour-channel (_in1) selection via shift_en.
module aibcr3_bsr_chain_nch #(
    parameter int unsigned NCH = 8
) (
    input logic                   jtag_clkdr_in,
    input logic                   jtag_rstb,
    aibcr3_bsr_chain_nch_if.slave bus
);
    localparam int unsigned L  = 3 * NCH;
    localparam int unsigned CW = $clog2(L + 1);
    localparam logic [CW-1:0] CntFull = CW'(L);

    logic [L-1:0]   sr_q, sr_d;
    logic [L-1:0]   upd_q, upd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] sel_idata0, sel_idata1, sel_itxen;

`ifdef AIBCR3_BSR_REDUNDANCY_EN
    always_comb begin
        sel_idata0 = (bus.shift_en & bus.idata0_in1) | (~bus.shift_en & bus.idata0_in0);
        sel_idata1 = (bus.shift_en & bus.idata1_in1) | (~bus.shift_en & bus.idata1_in0);
        sel_itxen  = (bus.shift_en & bus.itxen_in1)  | (~bus.shift_en & bus.itxen_in0);
    end
`else
    logic unused_redundancy;
    always_comb begin
        sel_idata0 = bus.idata0_in0;
        sel_idata1 = bus.idata1_in0;
        sel_itxen  = bus.itxen_in0;
        unused_redundancy = ^{bus.shift_en, bus.idata0_in1, bus.idata1_in1, bus.itxen_in1};
    end
`endif

    // Shift has priority; capture and update may fire together (update sees pre-edge sr).
    always_comb begin
        sr_d  = sr_q;
        upd_d = upd_q;
        cnt_d = cnt_q;
        if (bus.jtag_tx_scanen_in) begin
            sr_d  = {sr_q[L-2:0], bus.jtag_tx_scan_in};
            cnt_d = (cnt_q == CntFull) ? cnt_q : cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
            if (bus.jtag_capture) begin
                for (int i = 0; i < int'(NCH); i++) begin
                    sr_d[3*i]   = bus.odat0_aib[i];
                    sr_d[3*i+1] = bus.odat1_aib[i];
                    sr_d[3*i+2] = sel_itxen[i];
                end
            end
            if (bus.jtag_update) begin
                upd_d = sr_q;
            end
        end
    end

    always_ff @(posedge jtag_clkdr_in or negedge jtag_rstb) begin
        if (!jtag_rstb) begin
            sr_q  <= '0;
            upd_q <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            upd_q <= upd_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        bus.idata0_out = '0;
        bus.idata1_out = '0;
        bus.itxen_out  = '0;
        bus.odat0_out  = '0;
        bus.odat1_out  = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            bus.idata0_out[i] = bus.jtag_mode_in ? upd_q[3*i]   : sel_idata0[i];
            bus.idata1_out[i] = bus.jtag_mode_in ? upd_q[3*i+1] : sel_idata1[i];
            bus.itxen_out[i]  = bus.jtag_mode_in ? upd_q[3*i+2] : sel_itxen[i];
            bus.odat0_out[i]  = bus.jtag_intest  ? upd_q[3*i]   : bus.odat0_aib[i];
            bus.odat1_out[i]  = bus.jtag_intest  ? upd_q[3*i+1] : bus.odat1_aib[i];
        end
    end

    always_comb begin
        bus.jtag_rx_scan_out = sr_q[L-1];
        bus.scan_full        = (cnt_q == CntFull);
    end
endmodule

// File: tb/tb_aibcr3_bsr_chain_nch.sv
// Directed bench for aibcr3_bsr_chain_nch at NCH=2 (L=6): vector table plus hand sequences.
module tb_aibcr3_bsr_chain_nch;
    localparam int unsigned NCH = 2;

    logic clk = 1'b0;
    logic rstb;
    int   errors = 0;
    int   checks = 0;

    aibcr3_bsr_chain_nch_if #(.NCH(NCH)) bus ();

    aibcr3_bsr_chain_nch #(.NCH(NCH)) dut (
        .jtag_clkdr_in (clk),
        .jtag_rstb     (rstb),
        .bus           (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic se;
        logic si;
        logic cap;
        logic up;
        logic exp_so;
        logic exp_full;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic b);
        bus.jtag_tx_scanen_in = 1'b1;
        bus.jtag_tx_scan_in   = b;
        tick();
    endtask

    vec_t        vecs [9];
    logic [5:0]  exp_sr;
    logic [1:0]  exp_red;
    logic [5:0]  pat;

    initial begin
        // Shift 6'b101101 LSB first; first bit appears at scan out after clock 6.
        vecs[0] = '{se: 1, si: 1, cap: 0, up: 0, exp_so: 0, exp_full: 0};
        vecs[1] = '{se: 1, si: 0, cap: 0, up: 0, exp_so: 0, exp_full: 0};
        vecs[2] = '{se: 1, si: 1, cap: 0, up: 0, exp_so: 0, exp_full: 0};
        vecs[3] = '{se: 1, si: 1, cap: 0, up: 0, exp_so: 0, exp_full: 0};
        vecs[4] = '{se: 1, si: 0, cap: 0, up: 0, exp_so: 0, exp_full: 0};
        vecs[5] = '{se: 1, si: 1, cap: 0, up: 0, exp_so: 1, exp_full: 1};
        vecs[6] = '{se: 1, si: 0, cap: 0, up: 0, exp_so: 0, exp_full: 1};
        vecs[7] = '{se: 1, si: 0, cap: 1, up: 1, exp_so: 1, exp_full: 1};
        vecs[8] = '{se: 0, si: 0, cap: 0, up: 0, exp_so: 1, exp_full: 0};

        rstb = 1'b0;
        bus.jtag_tx_scan_in = 0; bus.jtag_tx_scanen_in = 0; bus.jtag_capture = 0;
        bus.jtag_update = 0; bus.jtag_mode_in = 1; bus.jtag_intest = 1;
        bus.shift_en = '0; bus.idata0_in0 = '0; bus.idata0_in1 = '0;
        bus.idata1_in0 = '0; bus.idata1_in1 = '0; bus.itxen_in0 = '0; bus.itxen_in1 = '0;
        bus.odat0_aib = 2'b11; bus.odat1_aib = 2'b11;
        #12;
        check("reset_so", 32'(bus.jtag_rx_scan_out), 32'h0);
        check("reset_full", 32'(bus.scan_full), 32'h0);
        check("reset_idata0", 32'(bus.idata0_out), 32'h0);
        check("reset_odat0", 32'(bus.odat0_out), 32'h0);
        bus.jtag_mode_in = 0; bus.jtag_intest = 0; bus.idata1_in0 = 2'b10;
        #1;
        check("reset_bypass_idata1", 32'(bus.idata1_out), 32'h2);
        check("reset_bypass_odat1", 32'(bus.odat1_out), 32'h3);
        bus.idata1_in0 = '0; bus.odat0_aib = '0; bus.odat1_aib = '0;
        rstb = 1'b1;

        for (int i = 0; i < 9; i++) begin
            bus.jtag_tx_scanen_in = vecs[i].se;
            bus.jtag_tx_scan_in   = vecs[i].si;
            bus.jtag_capture      = vecs[i].cap;
            bus.jtag_update       = vecs[i].up;
            tick();
            check($sformatf("vec%0d_so", i), 32'(bus.jtag_rx_scan_out), 32'(vecs[i].exp_so));
            check($sformatf("vec%0d_full", i), 32'(bus.scan_full), 32'(vecs[i].exp_full));
        end
        bus.jtag_capture = 0; bus.jtag_update = 0;
        // capture/update alongside shift must have been ignored
        bus.jtag_mode_in = 1;
        #1;
        check("shift_ignores_update", 32'(bus.idata0_out), 32'h0);
        bus.jtag_mode_in = 0;

        // Capture then shift out: sr = 6'b101110, MSB first.
        bus.odat0_aib = 2'b10; bus.odat1_aib = 2'b01; bus.itxen_in0 = 2'b11;
        bus.jtag_tx_scanen_in = 0; bus.jtag_capture = 1;
        tick();
        bus.jtag_capture = 0;
        exp_sr = 6'b101110;
        check("cap_bit0", 32'(bus.jtag_rx_scan_out), 32'(exp_sr[5]));
        for (int k = 1; k < 6; k++) begin
            shift_bit(1'b0);
            check($sformatf("cap_bit%0d", k), 32'(bus.jtag_rx_scan_out), 32'(exp_sr[5-k]));
        end

        // sr = all ones, then capture zeros and update in the same cycle.
        for (int k = 0; k < 6; k++) shift_bit(1'b1);
        bus.jtag_tx_scanen_in = 0;
        bus.odat0_aib = '0; bus.odat1_aib = '0; bus.itxen_in0 = '0;
        bus.jtag_capture = 1; bus.jtag_update = 1;
        tick();
        bus.jtag_capture = 0; bus.jtag_update = 0;
        bus.jtag_mode_in = 1; bus.jtag_intest = 1;
        #1;
        check("capupd_idata0", 32'(bus.idata0_out), 32'h3);
        check("capupd_idata1", 32'(bus.idata1_out), 32'h3);
        check("capupd_itxen", 32'(bus.itxen_out), 32'h3);
        check("capupd_odat1", 32'(bus.odat1_out), 32'h3);
        check("capupd_sr_msb", 32'(bus.jtag_rx_scan_out), 32'h0);
        bus.jtag_mode_in = 0; bus.jtag_intest = 0;

        // Redundancy mux on idata0.
        bus.shift_en = 2'b01; bus.idata0_in0 = 2'b00; bus.idata0_in1 = 2'b11;
`ifdef AIBCR3_BSR_REDUNDANCY_EN
        exp_red = 2'b01;
`else
        exp_red = 2'b00;
`endif
        #1;
        check("redundancy_idata0", 32'(bus.idata0_out), 32'(exp_red));
        bus.shift_en = '0; bus.idata0_in1 = '0;

        // upd = 6'b000111 via shift (first bit lands in sr[5]) then update.
        pat = 6'b000111;
        for (int k = 5; k >= 0; k--) shift_bit(pat[k]);
        bus.jtag_tx_scanen_in = 0; bus.jtag_update = 1;
        tick();
        bus.jtag_update = 0;
        bus.jtag_mode_in = 1; bus.jtag_intest = 1;
        #1;
        check("extest_idata0", 32'(bus.idata0_out), 32'h1);
        check("extest_idata1", 32'(bus.idata1_out), 32'h1);
        check("extest_itxen", 32'(bus.itxen_out), 32'h1);
        check("intest_odat0", 32'(bus.odat0_out), 32'h1);
        check("intest_odat1", 32'(bus.odat1_out), 32'h1);

        // Reset mid-shift clears everything immediately.
        for (int k = 0; k < 3; k++) shift_bit(1'b1);
        #2 rstb = 1'b0;
        #1;
        check("midrst_so", 32'(bus.jtag_rx_scan_out), 32'h0);
        check("midrst_full", 32'(bus.scan_full), 32'h0);
        check("midrst_idata0", 32'(bus.idata0_out), 32'h0);
        check("midrst_itxen", 32'(bus.itxen_out), 32'h0);
        check("midrst_odat0", 32'(bus.odat0_out), 32'h0);
        rstb = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            shift_bit(k == 1);
            check($sformatf("postrst_so%0d", k), 32'(bus.jtag_rx_scan_out), 32'(k == 6));
            check($sformatf("postrst_full%0d", k), 32'(bus.scan_full), 32'(k == 6));
        end
        bus.jtag_tx_scanen_in = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
